// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Anodes are active-low, so an unlit digit drives its anode bit to AN_OFF.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int   NIBBLE_W = 4;
  localparam logic AN_OFF   = 1'b1;

endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot cycle counter: counts 0..REFRESH_DIV-1 and flags the last blank
// cycle and the last cycle of the slot.
module seg_slot_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int TW          = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  output logic [TW-1:0] count,
  output logic          blank_end,
  output logic          slot_end
);

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] SLOT_LAST  = TW'(REFRESH_DIV - 1);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count_reg <= '0;
    end else if (count_reg == SLOT_LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count     = count_reg;
  assign blank_end = (count_reg == BLANK_LAST);
  assign slot_end  = (count_reg == SLOT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for DIGITS common-anode digits sharing one
// nibble-to-segment decoder, with inter-digit blanking and tear-free updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         EN,
  input  logic                         LOAD,
  input  logic [NIBBLE_W*DIGITS-1:0]   DATA_IN,
  input  logic [DIGITS-1:0]            DP_IN,
  input  logic                         LZ_EN,
  output logic                         N3,
  output logic                         N2,
  output logic                         N1,
  output logic                         N0,
  output logic [DIGITS-1:0]            AN,
  output logic                         DP,
  output logic                         BLANK,
  output logic                         FRAME_DONE
);

  localparam int IW = $clog2(DIGITS);
  localparam int TW = $clog2(REFRESH_DIV);
  localparam int DW = NIBBLE_W * DIGITS;

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [TW-1:0] PRE_TERM = TW'(REFRESH_DIV - 2);

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;

  logic [DW-1:0]     act_data_reg, act_data_next;
  logic [DIGITS-1:0] act_dp_reg, act_dp_next;
  logic [DW-1:0]     shd_data_reg, shd_data_next;
  logic [DIGITS-1:0] shd_dp_reg, shd_dp_next;
  logic              pending_reg, pending_next;

  logic [NIBBLE_W-1:0] n_reg, n_next;
  logic [DIGITS-1:0]   an_reg, an_next;
  logic                dp_reg, dp_next;
  logic                blank_reg, blank_next;
  logic                fd_reg, fd_next;

  logic [TW-1:0] timer_count;
  logic          timer_clear, blank_end, slot_end;
  logic          frame_done_now, commit_now;

  // Timer is held at zero while dark so the first slot always starts from 0.
  assign timer_clear = !EN || (state_reg == seg_pkg::IDLE);

  seg_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear    (timer_clear),
    .count    (timer_count),
    .blank_end(blank_end),
    .slot_end (slot_end)
  );

  assign frame_done_now = EN && (state_reg == seg_pkg::SHOW) && slot_end
                          && (idx_reg == LAST_IDX);
  assign commit_now     = EN && ((state_reg == seg_pkg::IDLE) || frame_done_now);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (!EN) begin
      state_next = seg_pkg::IDLE;
      idx_next   = '0;
    end else begin
      unique case (state_reg)
        seg_pkg::IDLE: begin
          state_next = seg_pkg::BLANK;
          idx_next   = '0;
        end
        seg_pkg::BLANK: begin
          if (blank_end) state_next = seg_pkg::SHOW;
        end
        seg_pkg::SHOW: begin
          if (slot_end) begin
            state_next = seg_pkg::BLANK;
            idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
          end
        end
        default: begin
          state_next = seg_pkg::IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  // A LOAD landing on a commit point bypasses the shadow and goes live directly.
  always_comb begin
    act_data_next = act_data_reg;
    act_dp_next   = act_dp_reg;
    shd_data_next = shd_data_reg;
    shd_dp_next   = shd_dp_reg;
    pending_next  = pending_reg;
    if (LOAD) begin
      shd_data_next = DATA_IN;
      shd_dp_next   = DP_IN;
    end
    if (commit_now) begin
      if (LOAD) begin
        act_data_next = DATA_IN;
        act_dp_next   = DP_IN;
        pending_next  = 1'b0;
      end else if (pending_reg) begin
        act_data_next = shd_data_reg;
        act_dp_next   = shd_dp_reg;
        pending_next  = 1'b0;
      end
    end else if (LOAD) begin
      pending_next = 1'b1;
    end
  end

  logic [NIBBLE_W-1:0] nib_next [DIGITS];
  logic [DIGITS-1:0]   zero_next;
  logic [DIGITS-1:0]   upper_zero;

  // upper_zero[i]: nibbles i..DIGITS-1 are all zero (leading-zero candidate).
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib_next[gi]   = act_data_next[gi*NIBBLE_W +: NIBBLE_W];
    assign zero_next[gi]  = (nib_next[gi] == '0);
    assign upper_zero[gi] = &zero_next[DIGITS-1:gi];
  end

  logic suppress_next, lit_next;

  // Outputs are computed from next-state values so the registers line up
  // with the state they describe.
  always_comb begin
    suppress_next = LZ_EN && (idx_next != '0) && upper_zero[idx_next];
    lit_next      = (state_next == seg_pkg::SHOW) && !suppress_next;
    n_next        = (state_next == seg_pkg::IDLE) ? '0 : nib_next[idx_next];
    an_next       = lit_next ? ~(DIGITS'(1) << idx_next) : {DIGITS{AN_OFF}};
    dp_next       = lit_next && act_dp_next[idx_next];
    blank_next    = !lit_next;
    fd_next       = (state_next == seg_pkg::SHOW) && (idx_next == LAST_IDX)
                    && (timer_count == PRE_TERM);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= seg_pkg::IDLE;
      idx_reg      <= '0;
      act_data_reg <= '0;
      act_dp_reg   <= '0;
      shd_data_reg <= '0;
      shd_dp_reg   <= '0;
      pending_reg  <= 1'b0;
      n_reg        <= '0;
      an_reg       <= {DIGITS{AN_OFF}};
      dp_reg       <= 1'b0;
      blank_reg    <= 1'b1;
      fd_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      act_data_reg <= act_data_next;
      act_dp_reg   <= act_dp_next;
      shd_data_reg <= shd_data_next;
      shd_dp_reg   <= shd_dp_next;
      pending_reg  <= pending_next;
      n_reg        <= n_next;
      an_reg       <= an_next;
      dp_reg       <= dp_next;
      blank_reg    <= blank_next;
      fd_reg       <= fd_next;
    end
  end

  assign {N3, N2, N1, N0} = n_reg;
  assign AN               = an_reg;
  assign DP               = dp_reg;
  assign BLANK            = blank_reg;
  assign FRAME_DONE       = fd_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors, directed corner sequences and a
// randomized run against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic        CLK = 1'b0;
  logic        RST_N, EN, LOAD, LZ_EN;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;
  logic        N3, N2, N1, N0;
  logic [3:0]  AN;
  logic        DP, BLANK, FRAME_DONE;

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .DATA_IN(DATA_IN),
    .DP_IN(DP_IN), .LZ_EN(LZ_EN), .N3(N3), .N2(N2), .N1(N1), .N0(N0),
    .AN(AN), .DP(DP), .BLANK(BLANK), .FRAME_DONE(FRAME_DONE)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: m_t counts cycles since scanning started.
  bit          m_run;
  int          m_t;
  logic [15:0] m_act, m_shd;
  logic [3:0]  m_actdp, m_shddp;
  bit          m_pend, m_lz;

  // Packed as {AN[3:0], N[3:0], DP, BLANK, FRAME_DONE}
  function automatic logic [10:0] model_out();
    int idx, off;
    logic [15:0] upper;
    logic [3:0] nib, an;
    bit lit, supp;
    if (!m_run) return {4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
    idx   = (m_t / R) % D;
    off   = m_t % R;
    upper = m_act >> (4 * idx);
    nib   = upper[3:0];
    supp  = m_lz && (idx != 0) && (upper == 16'h0);
    lit   = (off >= B) && !supp;
    an    = lit ? ~(4'b0001 << idx) : 4'hF;
    return {an, nib, lit & m_actdp[idx], !lit, (off == R - 1) && (idx == D - 1)};
  endfunction

  function automatic logic [10:0] dut_out();
    return {AN, N3, N2, N1, N0, DP, BLANK, FRAME_DONE};
  endfunction

  task automatic model_step();
    bit fd, commit;
    if (!RST_N) begin
      m_run = 0; m_t = 0; m_act = '0; m_shd = '0; m_actdp = '0; m_shddp = '0;
      m_pend = 0; m_lz = 0;
      return;
    end
    fd     = m_run && EN && (m_t % R == R - 1) && ((m_t / R) % D == D - 1);
    commit = EN && (!m_run || fd);
    if (LOAD) begin m_shd = DATA_IN; m_shddp = DP_IN; end
    if (commit) begin
      if (LOAD) begin
        m_act = DATA_IN; m_actdp = DP_IN; m_pend = 0;
      end else if (m_pend) begin
        m_act = m_shd; m_actdp = m_shddp; m_pend = 0;
      end
    end else if (LOAD) begin
      m_pend = 1;
    end
    if (!EN) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
    m_lz = LZ_EN;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check($sformatf("model_t%0d", m_t), 16'(dut_out()), 16'(model_out()));
  endtask

  task automatic run_until(input int idx, input int off);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_run && ((m_t / R) % D == idx) && (m_t % R == off)) && n < 200);
    check($sformatf("run_until_%0d_%0d", idx, off), 16'(n < 200), 16'd1);
  endtask

  typedef struct {
    logic        en, load, lz;
    logic [15:0] data;
    logic [3:0]  dp;
    int          ncyc;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic en, logic load, logic lz, logic [15:0] data,
                              logic [3:0] dp, int ncyc, logic [3:0] an, logic [3:0] n,
                              logic edp, logic eblank, logic efd);
    vec_t v;
    v.en = en; v.load = load; v.lz = lz; v.data = data; v.dp = dp; v.ncyc = ncyc;
    v.exp = {an, n, edp, eblank, efd};
    return v;
  endfunction

  initial begin
    // Each row: drive for ncyc cycles (LOAD only on the first), then compare.
    tbl[0]  = mk(0, 0, 0, 16'h0000, 4'b0000,  5, 4'hF, 4'h0, 0, 1, 0);
    tbl[1]  = mk(1, 1, 0, 16'h1234, 4'b0100,  1, 4'hF, 4'h4, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 16'h1234, 4'b0100,  2, 4'hE, 4'h4, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 16'h1234, 4'b0100,  8, 4'hD, 4'h3, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 16'h1234, 4'b0100,  8, 4'hB, 4'h2, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 16'h1234, 4'b0100, 13, 4'h7, 4'h1, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 16'h1234, 4'b0100,  1, 4'hF, 4'h4, 0, 1, 0);
    tbl[7]  = mk(1, 1, 1, 16'h0005, 4'b0000,  1, 4'hF, 4'h4, 0, 1, 0);
    tbl[8]  = mk(1, 0, 1, 16'h0005, 4'b0000, 30, 4'h7, 4'h1, 0, 0, 1);
    tbl[9]  = mk(1, 0, 1, 16'h0005, 4'b0000,  3, 4'hE, 4'h5, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 16'h0005, 4'b0000,  8, 4'hF, 4'h0, 0, 1, 0);
    tbl[11] = mk(1, 0, 1, 16'h0005, 4'b0000, 16, 4'hF, 4'h0, 0, 1, 0);
    tbl[12] = mk(1, 1, 1, 16'h0000, 4'b0000,  1, 4'hF, 4'h0, 0, 1, 0);
    tbl[13] = mk(1, 0, 1, 16'h0000, 4'b0000,  7, 4'hE, 4'h0, 0, 0, 0);

    RST_N = 0; EN = 0; LOAD = 0; LZ_EN = 0; DATA_IN = '0; DP_IN = '0;
    step(); step();
    check("reset_state", 16'(dut_out()), 16'({4'hF, 4'h0, 1'b0, 1'b1, 1'b0}));
    RST_N = 1;

    for (int i = 0; i < 14; i++) begin
      EN = tbl[i].en; LOAD = tbl[i].load; LZ_EN = tbl[i].lz;
      DATA_IN = tbl[i].data; DP_IN = tbl[i].dp;
      step();
      LOAD = 0;
      for (int c = 1; c < tbl[i].ncyc; c++) step();
      check($sformatf("tbl%0d", i), 16'(dut_out()), 16'(tbl[i].exp));
    end

    // Mid-frame LOAD waits for the frame boundary
    LZ_EN = 0; DATA_IN = 16'h1234; DP_IN = 4'b0000; LOAD = 1;
    step(); LOAD = 0;
    run_until(3, 7);
    run_until(1, 3);
    DATA_IN = 16'hABCD; LOAD = 1; step(); LOAD = 0;
    run_until(2, 3);
    check("midload_idx2_old", 16'({N3, N2, N1, N0}), 16'h2);
    run_until(3, 3);
    check("midload_idx3_old", 16'({N3, N2, N1, N0}), 16'h1);
    run_until(0, 3);
    check("midload_idx0_new", 16'({N3, N2, N1, N0}), 16'hD);

    // LOAD coincident with FRAME_DONE
    run_until(3, 7);
    check("fd_pulse", 16'(FRAME_DONE), 16'd1);
    DATA_IN = 16'h5678; LOAD = 1; step(); LOAD = 0;
    check("fd_pulse_1cyc", 16'(FRAME_DONE), 16'd0);
    run_until(0, 3);
    check("fdload_idx0", 16'({AN, N3, N2, N1, N0}), 16'hE8);

    // EN dropped in SHOW, then re-raised
    run_until(2, 4);
    EN = 0; step();
    check("en_drop_dark", 16'({AN, BLANK}), 16'b11111);
    step(); step();
    EN = 1; step();
    check("en_restart_blank", 16'({AN, N3, N2, N1, N0, BLANK}), 16'({4'hF, 4'h8, 1'b1}));
    step(); step();
    check("en_restart_show", 16'({AN, N3, N2, N1, N0}), 16'hE8);

    // One-cycle reset mid-SHOW
    run_until(1, 4);
    RST_N = 0; step();
    check("midreset", 16'(dut_out()), 16'({4'hF, 4'h0, 1'b0, 1'b1, 1'b0}));
    RST_N = 1; step(); step(); step();
    check("post_reset_active0", 16'({AN, N3, N2, N1, N0}), 16'hE0);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      RST_N   = ($urandom_range(0, 299) != 0);
      EN      = ($urandom_range(0, 99) < 96);
      LOAD    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) LZ_EN = ~LZ_EN;
      DATA_IN = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      DP_IN   = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
